// File: rtl/serial2parallel_aligner.sv
// Bit-clock deserializer: finds the K28.5 symbol boundary in a 1-bit serial stream,
// emits aligned 10-bit symbols and tracks lock with a SEARCH/LOCKED state machine.
module serial2parallel_aligner #(
    parameter logic [9:0] COMMA_NEG  = 10'b0011111010,
    parameter logic [9:0] COMMA_POS  = 10'b1100000101,
    parameter int         UNLOCK_CNT = 3
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       in_1b,
    input  logic       in_valid,
    output logic [9:0] out_10b,
    output logic       out_valid,
    output logic       comma_det,
    output logic       aligned,
    output logic       align_err
);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] UNLOCK_CNT_W = 4'(UNLOCK_CNT);
    localparam logic [3:0] LAST_BIT     = 4'd9;

    state_t     r_state;
    logic [9:0] r_shreg;
    logic [3:0] r_bit_cnt;
    logic [3:0] r_miss_cnt;
    logic [9:0] r_out_10b;
    logic       r_out_valid;
    logic       r_comma_det;
    logic       r_aligned;
    logic       r_align_err;

    state_t     w_state_next;
    logic [9:0] w_shreg_next;
    logic [3:0] w_bit_cnt_next;
    logic [3:0] w_miss_cnt_next;
    logic [9:0] w_out_10b_next;
    logic       w_out_valid_next;
    logic       w_comma_det_next;
    logic       w_aligned_next;
    logic       w_align_err_next;

    logic [9:0] w_win;
    logic       w_is_comma;
    logic [3:0] w_miss_inc;
    logic       w_at_boundary;

    // The window always includes the bit being sampled this cycle.
    assign w_win         = {r_shreg[8:0], in_1b};
    assign w_is_comma    = (w_win == COMMA_NEG) || (w_win == COMMA_POS);
    assign w_miss_inc    = r_miss_cnt + 4'd1;
    assign w_at_boundary = (r_bit_cnt == LAST_BIT);

    always_comb begin
        w_state_next     = r_state;
        w_shreg_next     = r_shreg;
        w_bit_cnt_next   = r_bit_cnt;
        w_miss_cnt_next  = r_miss_cnt;
        w_out_10b_next   = r_out_10b;
        w_out_valid_next = 1'b0;
        w_comma_det_next = 1'b0;
        w_align_err_next = 1'b0;

        if (in_valid) begin
            w_shreg_next = w_win;
            unique case (r_state)
                ST_SEARCH: begin
                    if (w_is_comma) begin
                        w_out_10b_next   = w_win;
                        w_out_valid_next = 1'b1;
                        w_comma_det_next = 1'b1;
                        w_bit_cnt_next   = 4'd0;
                        w_miss_cnt_next  = 4'd0;
                        w_state_next     = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    w_bit_cnt_next = w_at_boundary ? 4'd0 : (r_bit_cnt + 4'd1);
                    if (w_at_boundary) begin
                        w_out_10b_next   = w_win;
                        w_out_valid_next = 1'b1;
                        w_comma_det_next = w_is_comma;
                        if (w_is_comma) begin
                            w_miss_cnt_next = 4'd0;
                        end
                    end else if (w_is_comma) begin
                        // Comma off the locked phase: count it, drop lock after enough of them.
                        w_align_err_next = 1'b1;
                        if (w_miss_inc == UNLOCK_CNT_W) begin
                            w_miss_cnt_next = 4'd0;
                            w_state_next    = ST_SEARCH;
                        end else begin
                            w_miss_cnt_next = w_miss_inc;
                        end
                    end
                end
            endcase
        end

        w_aligned_next = (w_state_next == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= ST_SEARCH;
            r_shreg     <= 10'd0;
            r_bit_cnt   <= 4'd0;
            r_miss_cnt  <= 4'd0;
            r_out_10b   <= 10'd0;
            r_out_valid <= 1'b0;
            r_comma_det <= 1'b0;
            r_aligned   <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_shreg     <= w_shreg_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_miss_cnt  <= w_miss_cnt_next;
            r_out_10b   <= w_out_10b_next;
            r_out_valid <= w_out_valid_next;
            r_comma_det <= w_comma_det_next;
            r_aligned   <= w_aligned_next;
            r_align_err <= w_align_err_next;
        end
    end

    assign out_10b   = r_out_10b;
    assign out_valid = r_out_valid;
    assign comma_det = r_comma_det;
    assign aligned   = r_aligned;
    assign align_err = r_align_err;

endmodule

// File: tb/tb_serial2parallel_aligner.sv
// Self-checking bench for serial2parallel_aligner: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural alignment model.
module tb_serial2parallel_aligner;

    localparam logic [9:0] CN     = 10'b0011111010;
    localparam logic [9:0] CP     = 10'b1100000101;
    localparam int         UNLOCK = 3;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       in_1b;
    logic       in_valid;
    logic [9:0] out_10b;
    logic       out_valid;
    logic       comma_det;
    logic       aligned;
    logic       align_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model: bit history as an integer window, lock as "bits since lock".
    int         m_win;
    int         m_since;
    int         m_miss;
    bit         m_locked;
    logic [9:0] e_out;
    logic       e_ov, e_cd, e_ae, e_al;

    int cnt_ov, cnt_cd, cnt_ae;

    serial2parallel_aligner #(
        .COMMA_NEG (CN),
        .COMMA_POS (CP),
        .UNLOCK_CNT(UNLOCK)
    ) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .in_1b    (in_1b),
        .in_valid (in_valid),
        .out_10b  (out_10b),
        .out_valid(out_valid),
        .comma_det(comma_det),
        .aligned  (aligned),
        .align_err(align_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_win = 0; m_since = 0; m_miss = 0; m_locked = 0;
        e_out = '0; e_ov = 0; e_cd = 0; e_ae = 0; e_al = 0;
    endtask

    task automatic model_step(input logic b, input logic v);
        bit is_c;
        e_ov = 0; e_cd = 0; e_ae = 0;
        if (v) begin
            m_win = (m_win * 2 + int'(b)) % 1024;
            is_c  = (m_win == int'(CN)) || (m_win == int'(CP));
            if (!m_locked) begin
                if (is_c) begin
                    e_ov = 1; e_cd = 1; e_out = 10'(m_win);
                    m_locked = 1; m_since = 0; m_miss = 0;
                end
            end else begin
                m_since++;
                if (m_since % 10 == 0) begin
                    e_ov = 1; e_cd = is_c; e_out = 10'(m_win);
                    if (is_c) m_miss = 0;
                end else if (is_c) begin
                    e_ae = 1;
                    m_miss++;
                    if (m_miss == UNLOCK) begin
                        m_locked = 0; m_miss = 0;
                    end
                end
            end
        end
        e_al = m_locked;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 10'(out_valid), 10'(e_ov));
        chk({tag, ".comma_det"}, 10'(comma_det), 10'(e_cd));
        chk({tag, ".align_err"}, 10'(align_err), 10'(e_ae));
        chk({tag, ".aligned"},   10'(aligned),   10'(e_al));
        chk({tag, ".out_10b"},   out_10b,        e_out);
    endtask

    task automatic step(input string tag, input logic b, input logic v);
        @(negedge clk);
        in_1b = b; in_valid = v;
        @(posedge clk);
        #1;
        model_step(b, v);
        check_all(tag);
        if (out_valid) begin
            cnt_ov++;
            $display("[%0t] %s: symbol %b comma=%0d aligned=%0d", $time, tag, out_10b, comma_det, aligned);
        end
        if (comma_det) cnt_cd++;
        if (align_err) cnt_ae++;
    endtask

    task automatic send_sym(input string tag, input logic [9:0] s);
        for (int i = 9; i >= 0; i--) step(tag, s[i], 1'b1);
    endtask

    // Random bit with occasional idle cycles in front of it.
    task automatic send_rand_bit(input string tag, input logic b);
        while ($urandom_range(0, 7) == 0) step(tag, logic'($urandom_range(0, 1)), 1'b0);
        step(tag, b, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0; in_valid = 1'b0; in_1b = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        check_all("reset");
        reset_L = 1'b1;
    endtask

    task automatic clear_counts();
        cnt_ov = 0; cnt_cd = 0; cnt_ae = 0;
    endtask

    initial begin
        logic [9:0] sym;
        logic       b;
        int         kind;

        reset_L = 1'b0; in_1b = 1'b0; in_valid = 1'b0;
        model_reset();

        // T1: junk, comma, data
        do_reset();
        step("t1_junk", 1'b1, 1'b1);
        step("t1_junk", 1'b0, 1'b1);
        step("t1_junk", 1'b1, 1'b1);
        send_sym("t1_comma", CN);
        chk("t1_comma_value", out_10b, 10'b0011111010);
        chk("t1_comma_strobe", 10'({out_valid, comma_det, aligned}), 10'b111);
        send_sym("t1_data", 10'b1010101010);
        chk("t1_data_value", out_10b, 10'b1010101010);
        chk("t1_data_strobe", 10'({out_valid, comma_det}), 10'b10);

        // T2: three symbols at the locked phase
        clear_counts();
        send_sym("t2", 10'b1110010110);
        send_sym("t2", 10'b1100000101);
        send_sym("t2", 10'b0110100101);
        chk("t2_strobes", 10'(cnt_ov), 10'd3);
        chk("t2_commas", 10'(cnt_cd), 10'd1);
        chk("t2_align_err", 10'(cnt_ae), 10'd0);

        // T3: phase slip by one bit, repeated commas drop and regain lock
        clear_counts();
        send_sym("t3_pre", CN);
        step("t3_slip", 1'b1, 1'b1);
        send_sym("t3_shift", CN);
        send_sym("t3_shift", CN);
        send_sym("t3_shift", CN);
        chk("t3_err_count", 10'(cnt_ae), 10'd3);
        chk("t3_unlocked", 10'(aligned), 10'd0);
        send_sym("t3_relock", CN);
        chk("t3_relock_value", out_10b, CN);
        chk("t3_relock_strobe", 10'({out_valid, comma_det, aligned}), 10'b111);
        send_sym("t3_after", CP);
        chk("t3_after_value", out_10b, CP);

        // T4: idle gap in the middle of a symbol
        clear_counts();
        sym = 10'b1011001110;
        for (int i = 9; i >= 6; i--) step("t4", sym[i], 1'b1);
        for (int i = 0; i < 7; i++) step("t4_idle", logic'($urandom_range(0, 1)), 1'b0);
        chk("t4_no_strobe", 10'(cnt_ov), 10'd0);
        for (int i = 5; i >= 0; i--) step("t4", sym[i], 1'b1);
        chk("t4_value", out_10b, sym);
        chk("t4_strobe", 10'(out_valid), 10'd1);
        send_sym("t4_next", CN);
        chk("t4_phase_kept", 10'({out_valid, comma_det}), 10'b11);

        // T5: asynchronous reset mid-symbol while locked
        step("t5", 1'b1, 1'b1);
        step("t5", 1'b0, 1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        check_all("t5_async");
        @(negedge clk);
        reset_L = 1'b1;
        clear_counts();
        send_sym("t5_data", 10'b1010101010);
        send_sym("t5_data", 10'b0110100101);
        chk("t5_no_output", 10'(cnt_ov), 10'd0);
        send_sym("t5_comma", CP);
        chk("t5_relock", 10'({out_valid, comma_det, aligned}), 10'b111);

        // T6: 200 random bits free of any comma window
        do_reset();
        clear_counts();
        for (int i = 0; i < 200; i++) begin
            b = logic'($urandom_range(0, 1));
            if ((((m_win * 2 + int'(b)) % 1024) == int'(CN)) ||
                (((m_win * 2 + int'(b)) % 1024) == int'(CP))) b = ~b;
            step("t6", b, 1'b1);
        end
        chk("t6_no_output", 10'(cnt_ov), 10'd0);
        chk("t6_unaligned", 10'(aligned), 10'd0);

        // Randomized traffic: commas, data, phase slips, idles
        do_reset();
        for (int n = 0; n < 180; n++) begin
            kind = int'($urandom_range(0, 5));
            if (kind <= 1) sym = (kind == 0) ? CN : CP;
            else           sym = 10'($urandom);
            if (kind == 5) begin
                send_rand_bit("rand_slip", logic'($urandom_range(0, 1)));
            end else begin
                for (int i = 9; i >= 0; i--) send_rand_bit("rand", sym[i]);
            end
            if (n == 120) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
